spi_slave_rx: RTL and testbench

FPGA-side SPI responder for the link from the robot MCU to the motor-control FPGA. Runs entirely in the FPGA `clk` domain: oversamples the MCU's `sck`/`mosi`/`ncs`, deserialises MSB-first words into `rx_data`, and serialises `tx_data` onto `miso`. It sits between the top-level SPI pins and the command/status logic that feeds the per-driver and per-ADC SPI masters.

---
 rtl/spi_slave_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// FPGA-side SPI mode 0 responder for the MCU -> motor-control link.
// All logic runs in the clk domain: the MCU pins are oversampled through
// synchroniser chains, edges are decoded locally, MOSI is deserialised
// MSB-first into rx_data and tx_data is serialised MSB-first onto miso.
//
// Ports:
//   clk        system clock, at least 8x the sck frequency
//   reset      synchronous, active-high
//   sck        SPI clock from the MCU (asynchronous)
//   mosi       SPI data from the MCU (asynchronous)
//   ncs        SPI chip select, active-low (asynchronous)
//   miso       SPI data to the MCU
//   miso_oe    output enable for the miso pad driver
//   tx_data    next word to transmit, sampled when tx_ack fires
//   tx_ack     one-cycle pulse, tx_data was latched on this edge
//   rx_data    last complete received word
//   rx_valid   one-cycle pulse, rx_data was updated on this edge
//   frame_err  one-cycle pulse, ncs deasserted mid-word
//   busy       frame in progress (synchronised ncs low and armed)
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  ncs,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ack,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sckSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic [SYNC_STAGES-1:0] ncsSync_q;
    logic                   sckHist_q;
    logic                   ncsHist_q;

    logic sckS;
    logic mosiS;
    logic ncsS;
    logic sckRise;
    logic sckFall;
    logic ncsRise;
    logic ncsFall;

    state_t                 state_q,    state_d;
    logic [DATA_WIDTH-1:0]  shiftIn_q,  shiftIn_d;
    logic [DATA_WIDTH-1:0]  shiftOut_q, shiftOut_d;
    logic [CNT_W-1:0]       bitCnt_q,   bitCnt_d;
    logic                   wordDone_q, wordDone_d;
    logic [DATA_WIDTH-1:0]  rxData_q,   rxData_d;
    logic                   rxValid_q,  rxValid_d;
    logic                   txAck_q,    txAck_d;
    logic                   frameErr_q, frameErr_d;
    logic                   miso_q,     miso_d;
    logic                   misoOe_q,   misoOe_d;
    logic                   busy_q,     busy_d;
    logic [DATA_WIDTH-1:0]  shiftedIn;

    // The synchronisers and history flops run freely, even during reset, so
    // that the reset branch below can see a settled ncs level and decide
    // whether a frame was already in flight when reset was applied.
    always_ff @(posedge clk) begin
        sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], sck};
        mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
        ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], ncs};
        sckHist_q  <= sckSync_q[SYNC_STAGES-1];
        ncsHist_q  <= ncsSync_q[SYNC_STAGES-1];
    end

    // Edges compare the last synchroniser stage with its one-cycle-old copy,
    // so every decoded edge acts two clk edges after the pin was first sampled.
    always_comb begin
        sckS    = sckSync_q[SYNC_STAGES-1];
        mosiS   = mosiSync_q[SYNC_STAGES-1];
        ncsS    = ncsSync_q[SYNC_STAGES-1];
        sckRise = sckS & ~sckHist_q;
        sckFall = ~sckS & sckHist_q;
        ncsRise = ncsS & ~ncsHist_q;
        ncsFall = ~ncsS & ncsHist_q;
    end

    // State and datapath registers. A reset that lands while ncs is low parks
    // the block in WAIT_HIGH so the tail of that frame is never mistaken for
    // the start of a new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ncsS ? IDLE : WAIT_HIGH;
            shiftIn_q  <= '0;
            shiftOut_q <= '0;
            bitCnt_q   <= '0;
            wordDone_q <= 1'b0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            txAck_q    <= 1'b0;
            frameErr_q <= 1'b0;
            miso_q     <= 1'b0;
            misoOe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftIn_q  <= shiftIn_d;
            shiftOut_q <= shiftOut_d;
            bitCnt_q   <= bitCnt_d;
            wordDone_q <= wordDone_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            txAck_q    <= txAck_d;
            frameErr_q <= frameErr_d;
            miso_q     <= miso_d;
            misoOe_q   <= misoOe_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic. Everything holds by default and the three pulses
    // default low. Inside SHIFT an ncs rise is checked first so that it wins
    // over an sck edge decoded in the same cycle.
    always_comb begin
        state_d    = state_q;
        shiftIn_d  = shiftIn_q;
        shiftOut_d = shiftOut_q;
        bitCnt_d   = bitCnt_q;
        wordDone_d = wordDone_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        txAck_d    = 1'b0;
        frameErr_d = 1'b0;
        miso_d     = miso_q;
        misoOe_d   = misoOe_q;
        busy_d     = busy_q;
        shiftedIn  = {shiftIn_q[DATA_WIDTH-2:0], mosiS};

        case (state_q)
            IDLE: begin
                if (ncsFall) begin
                    shiftOut_d = tx_data;
                    miso_d     = tx_data[DATA_WIDTH-1];
                    txAck_d    = 1'b1;
                    bitCnt_d   = '0;
                    wordDone_d = 1'b0;
                    misoOe_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                if (ncsRise) begin
                    // A nonzero count means the MCU stopped mid-word; the
                    // partial word is dropped and rx_data keeps its value.
                    frameErr_d = (bitCnt_q != '0);
                    bitCnt_d   = '0;
                    wordDone_d = 1'b0;
                    miso_d     = 1'b0;
                    misoOe_d   = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (sckRise) begin
                    shiftIn_d = shiftedIn;
                    if (bitCnt_q == LAST_BIT) begin
                        rxData_d   = shiftedIn;
                        rxValid_d  = 1'b1;
                        wordDone_d = 1'b1;
                        bitCnt_d   = '0;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end else if (sckFall) begin
                    // The fall after the last bit of a word reloads the
                    // transmitter, so a back-to-back word starts with its MSB
                    // already on miso.
                    if (wordDone_q) begin
                        shiftOut_d = tx_data;
                        miso_d     = tx_data[DATA_WIDTH-1];
                        txAck_d    = 1'b1;
                        wordDone_d = 1'b0;
                    end else begin
                        shiftOut_d = {shiftOut_q[DATA_WIDTH-2:0], 1'b0};
                        miso_d     = shiftOut_q[DATA_WIDTH-2];
                    end
                end
            end

            WAIT_HIGH: begin
                if (ncsS) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign miso      = miso_q;
    assign miso_oe   = misoOe_q;
    assign tx_ack    = txAck_q;
    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign frame_err = frameErr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
// Drives spi_slave_rx as an SPI mode 0 master running at clk/8 and checks it
// against a queue-based model: words sent on mosi must come back in rx_data
// in order, and the bits read on miso must equal the tx_data words that were
// present whenever tx_ack fired.
module tb_spi_slave_rx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sck;
    logic          mosi;
    logic          ncs;
    logic          miso;
    logic          miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_ack;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    int nChecks = 0;
    int nFail   = 0;

    logic [DW-1:0] sendQ[$];
    logic [DW-1:0] rxQ[$];
    logic [DW-1:0] txLatched[$];
    logic [DW-1:0] txSrc[$];
    logic [DW-1:0] misoQ[$];

    int txAckCnt;
    int rxValidCnt;
    int frameErrCnt;
    int longPulseCnt;
    int coincideCnt;

    logic [DW-1:0] misoShift;
    int            misoBits;
    logic          prevAck;
    logic          prevRx;
    logic          prevErr;

    spi_slave_rx #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .mosi     (mosi),
        .ncs      (ncs),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Hard time limit in case the stimulus process ever stalls.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Observes the DUT once per negedge: logs pulses, records the tx word
    // captured at each tx_ack and supplies the next one, as upstream would.
    task automatic sampleOutputs();
        if (!reset) begin
            if (tx_ack) begin
                txAckCnt++;
                txLatched.push_back(tx_data);
                if (txSrc.size() > 0) tx_data = txSrc.pop_front();
                else                  tx_data = DW'($urandom);
            end
            if (rx_valid) begin
                rxValidCnt++;
                rxQ.push_back(rx_data);
            end
            if (frame_err) frameErrCnt++;
            if ((tx_ack && prevAck) || (rx_valid && prevRx) || (frame_err && prevErr))
                longPulseCnt++;
            if (tx_ack && rx_valid) coincideCnt++;
        end
        prevAck = tx_ack;
        prevRx  = rx_valid;
        prevErr = frame_err;
    endtask

    task automatic waitClk(input int n);
        repeat (n) begin
            @(negedge clk);
            sampleOutputs();
        end
    endtask

    task automatic clearLogs();
        rxQ.delete();
        txLatched.delete();
        txSrc.delete();
        misoQ.delete();
        misoBits     = 0;
        misoShift    = '0;
        txAckCnt     = 0;
        rxValidCnt   = 0;
        frameErrCnt  = 0;
        longPulseCnt = 0;
        coincideCnt  = 0;
    endtask

    // One sck period at clk/8: mosi set at the fall, miso read just before
    // the rise, as an SPI mode 0 master would.
    task automatic clockBit(input logic b);
        mosi = b;
        waitClk(4);
        misoShift = {misoShift[DW-2:0], miso};
        misoBits++;
        if (misoBits % DW == 0) misoQ.push_back(misoShift);
        sck = 1'b1;
        waitClk(4);
        sck = 1'b0;
    endtask

    task automatic spiFrame(input int nBits);
        ncs  = 1'b0;
        mosi = 1'b0;
        waitClk(4);
        for (int i = 0; i < nBits; i++) begin
            logic [DW-1:0] w;
            w = sendQ[i / DW];
            clockBit(w[DW-1-(i % DW)]);
        end
        waitClk(4);
        ncs = 1'b1;
        waitClk(8);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ncs     = 1'b1;
        sck     = 1'b0;
        mosi    = 1'b0;
        tx_data = '0;
        prevAck = 1'b0;
        prevRx  = 1'b0;
        prevErr = 1'b0;
        clearLogs();
        waitClk(6);
        reset = 1'b0;
        waitClk(2);
        nChecks++; if (miso !== 1'b0) begin nFail++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
        nChecks++; if (miso_oe !== 1'b0) begin nFail++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        nChecks++; if (tx_ack !== 1'b0) begin nFail++; $display("[TB] FAIL reset_tx_ack: got %b expected 0", tx_ack); end
        nChecks++; if (rx_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        nChecks++; if (frame_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        nChecks++; if (rx_data !== 16'h0000) begin nFail++; $display("[TB] FAIL reset_rx_data: got %h expected 0000", rx_data); end
    endtask

    task automatic test_single_word();
        clearLogs();
        tx_data = 16'hA55A;
        sendQ.delete();
        sendQ.push_back(16'h1234);
        ncs  = 1'b0;
        mosi = 1'b0;
        waitClk(4);
        nChecks++; if (txAckCnt !== 1) begin nFail++; $display("[TB] FAIL single_start_ack: got %0d expected 1", txAckCnt); end
        nChecks++; if (miso_oe !== 1'b1) begin nFail++; $display("[TB] FAIL single_miso_oe: got %b expected 1", miso_oe); end
        nChecks++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        nChecks++; if (miso !== 1'b1) begin nFail++; $display("[TB] FAIL single_first_msb: got %b expected 1", miso); end
        for (int i = 0; i < DW; i++) clockBit(sendQ[0][DW-1-i]);
        waitClk(4);
        ncs = 1'b1;
        waitClk(8);
        nChecks++; if (rxValidCnt !== 1) begin nFail++; $display("[TB] FAIL single_rx_count: got %0d expected 1", rxValidCnt); end
        nChecks++; if (rx_data !== 16'h1234) begin nFail++; $display("[TB] FAIL single_rx_data: got %h expected 1234", rx_data); end
        nChecks++; if (misoQ.size() != 1 || misoQ[0] !== 16'hA55A) begin nFail++; $display("[TB] FAIL single_miso_word: got %h (count %0d) expected a55a", misoQ.size() > 0 ? misoQ[0] : 16'hxxxx, misoQ.size()); end
        nChecks++; if (frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL single_frame_err: got %0d expected 0", frameErrCnt); end
        // Start-of-frame load plus the reload on the fall after the last bit.
        nChecks++; if (txAckCnt !== 2) begin nFail++; $display("[TB] FAIL single_total_acks: got %0d expected 2", txAckCnt); end
        nChecks++; if (miso_oe !== 1'b0 || miso !== 1'b0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL single_end_idle: got oe=%b miso=%b busy=%b expected 0 0 0", miso_oe, miso, busy); end
        nChecks++; if (longPulseCnt !== 0) begin nFail++; $display("[TB] FAIL single_pulse_width: got %0d wide pulses expected 0", longPulseCnt); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] expMiso[3];
        expMiso = '{16'h1111, 16'h2222, 16'h3333};
        clearLogs();
        tx_data = 16'h1111;
        txSrc.push_back(16'h2222);
        txSrc.push_back(16'h3333);
        txSrc.push_back(16'h4444);
        sendQ.delete();
        sendQ.push_back(16'h0001);
        sendQ.push_back(16'h8000);
        sendQ.push_back(16'hFFFF);
        spiFrame(3 * DW);
        nChecks++; if (rxValidCnt !== 3) begin nFail++; $display("[TB] FAIL b2b_rx_count: got %0d expected 3", rxValidCnt); end
        nChecks++; if (txAckCnt !== 4) begin nFail++; $display("[TB] FAIL b2b_ack_count: got %0d expected 4", txAckCnt); end
        for (int i = 0; i < 3; i++) begin
            if (i < rxQ.size()) begin
                nChecks++; if (rxQ[i] !== sendQ[i]) begin nFail++; $display("[TB] FAIL b2b_rx_word%0d: got %h expected %h", i, rxQ[i], sendQ[i]); end
            end
            if (i < misoQ.size()) begin
                nChecks++; if (misoQ[i] !== expMiso[i]) begin nFail++; $display("[TB] FAIL b2b_miso_word%0d: got %h expected %h", i, misoQ[i], expMiso[i]); end
            end
        end
        nChecks++; if (frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", frameErrCnt); end
        nChecks++; if (coincideCnt !== 0) begin nFail++; $display("[TB] FAIL b2b_ack_rx_overlap: got %0d expected 0", coincideCnt); end
    endtask

    task automatic test_abort();
        logic [DW-1:0] prior;
        logic [DW-1:0] word;
        prior = rx_data;
        clearLogs();
        sendQ.delete();
        sendQ.push_back(16'hBEEF);
        spiFrame(9);
        nChecks++; if (frameErrCnt !== 1) begin nFail++; $display("[TB] FAIL abort_frame_err: got %0d expected 1", frameErrCnt); end
        nChecks++; if (rxValidCnt !== 0) begin nFail++; $display("[TB] FAIL abort_rx_count: got %0d expected 0", rxValidCnt); end
        nChecks++; if (rx_data !== 16'hFFFF) begin nFail++; $display("[TB] FAIL abort_rx_hold: got %h expected ffff (prior %h)", rx_data, prior); end
        clearLogs();
        word = 16'h00FF;
        sendQ.delete();
        sendQ.push_back(word);
        spiFrame(DW);
        nChecks++; if (rx_data !== 16'h00FF || rxValidCnt !== 1) begin nFail++; $display("[TB] FAIL abort_recover_rx: got %h (count %0d) expected 00ff (count 1)", rx_data, rxValidCnt); end
        nChecks++; if (misoQ.size() != 1 || txLatched.size() < 1 || misoQ[0] !== txLatched[0]) begin nFail++; $display("[TB] FAIL abort_recover_miso: got %0d words expected first word of %0d latched", misoQ.size(), txLatched.size()); end
        nChecks++; if (frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL abort_recover_err: got %0d expected 0", frameErrCnt); end
    endtask

    task automatic test_reset_mid_frame();
        clearLogs();
        ncs  = 1'b0;
        mosi = 1'b0;
        waitClk(4);
        for (int i = 0; i < 5; i++) clockBit(1'($urandom));
        reset = 1'b1;
        waitClk(2);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) clockBit(1'($urandom));
        waitClk(2);
        nChecks++; if (rxValidCnt !== 0) begin nFail++; $display("[TB] FAIL midreset_rx_count: got %0d expected 0", rxValidCnt); end
        nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        nChecks++; if (miso_oe !== 1'b0) begin nFail++; $display("[TB] FAIL midreset_miso_oe: got %b expected 0", miso_oe); end
        nChecks++; if (rx_data !== 16'h0000) begin nFail++; $display("[TB] FAIL midreset_rx_data: got %h expected 0000", rx_data); end
        ncs = 1'b1;
        waitClk(8);
        nChecks++; if (frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL midreset_frame_err: got %0d expected 0", frameErrCnt); end
        clearLogs();
        sendQ.delete();
        sendQ.push_back(16'hC0DE);
        spiFrame(DW);
        nChecks++; if (rx_data !== 16'hC0DE || rxValidCnt !== 1) begin nFail++; $display("[TB] FAIL midreset_next_frame: got %h (count %0d) expected c0de (count 1)", rx_data, rxValidCnt); end
    endtask

    task automatic test_glitch_idle();
        logic [DW-1:0] word;
        clearLogs();
        ncs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sck  = 1'b1;
            mosi = 1'($urandom);
            waitClk($urandom_range(1, 4));
            sck = 1'b0;
            waitClk($urandom_range(1, 4));
        end
        waitClk(4);
        nChecks++; if (txAckCnt + rxValidCnt + frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL glitch_pulses: got ack=%0d rx=%0d err=%0d expected none", txAckCnt, rxValidCnt, frameErrCnt); end
        nChecks++; if (miso_oe !== 1'b0 || miso !== 1'b0 || busy !== 1'b0) begin nFail++; $display("[TB] FAIL glitch_idle_pins: got oe=%b miso=%b busy=%b expected 0 0 0", miso_oe, miso, busy); end
        // A clean frame right afterwards shows the bit counter was untouched.
        word = DW'($urandom);
        sendQ.delete();
        sendQ.push_back(word);
        spiFrame(DW);
        nChecks++; if (rxQ.size() != 1 || rxQ[0] !== word) begin nFail++; $display("[TB] FAIL glitch_next_frame: got %0d words, rx_data %h expected %h", rxQ.size(), rx_data, word); end
        nChecks++; if (frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL glitch_next_err: got %0d expected 0", frameErrCnt); end
    endtask

    task automatic test_speed_limit();
        localparam int FRAMES = 20;
        localparam int WORDS  = 5;
        logic [DW-1:0] expRx[$];
        clearLogs();
        tx_data = DW'($urandom);
        for (int f = 0; f < FRAMES; f++) begin
            sendQ.delete();
            for (int w = 0; w < WORDS; w++) begin
                sendQ.push_back(DW'($urandom));
                expRx.push_back(sendQ[w]);
            end
            spiFrame(WORDS * DW);
        end
        nChecks++; if (rxQ.size() != FRAMES * WORDS) begin nFail++; $display("[TB] FAIL speed_rx_count: got %0d expected %0d", rxQ.size(), FRAMES * WORDS); end
        nChecks++; if (txLatched.size() != FRAMES * (WORDS + 1)) begin nFail++; $display("[TB] FAIL speed_ack_count: got %0d expected %0d", txLatched.size(), FRAMES * (WORDS + 1)); end
        for (int i = 0; i < rxQ.size() && i < expRx.size(); i++) begin
            nChecks++; if (rxQ[i] !== expRx[i]) begin nFail++; $display("[TB] FAIL speed_rx_word%0d: got %h expected %h", i, rxQ[i], expRx[i]); end
        end
        // Each frame latches WORDS+1 words; the last one is never shifted out.
        for (int i = 0; i < misoQ.size(); i++) begin
            int idx;
            idx = (i / WORDS) * (WORDS + 1) + (i % WORDS);
            if (idx < txLatched.size()) begin
                nChecks++; if (misoQ[i] !== txLatched[idx]) begin nFail++; $display("[TB] FAIL speed_miso_word%0d: got %h expected %h", i, misoQ[i], txLatched[idx]); end
            end
        end
        nChecks++; if (frameErrCnt !== 0) begin nFail++; $display("[TB] FAIL speed_frame_err: got %0d expected 0", frameErrCnt); end
        nChecks++; if (longPulseCnt !== 0) begin nFail++; $display("[TB] FAIL speed_pulse_width: got %0d wide pulses expected 0", longPulseCnt); end
        nChecks++; if (coincideCnt !== 0) begin nFail++; $display("[TB] FAIL speed_ack_rx_overlap: got %0d expected 0", coincideCnt); end
    endtask

    // Scenario sequence; each task leaves ncs high and the block idle.
    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        test_glitch_idle();
        test_speed_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
